fifo_word_packer: RTL and testbench
===================================

// Module: fifo_word_packer
// PURPOSE
//  Downstream drain stage for the 256x8 byte FIFO: pops bytes via read_req/read_data/empty,
//  packs BYTES_PER_WORD bytes little-endian into one word, presents it on a valid/ready port.
//  Idle timeout flushes a partial word with byte-enable mask. Sits between FIFO and bus/DMA sink.
// PARAMETERS
//  DATA_W          8   FIFO byte width; must match FIFO write_data/read_data width
//  BYTES_PER_WORD  4   bytes per output word (power of 2, 2..8)
//  TIMEOUT         16  idle cycles with partial word and FIFO empty before flush (>=1)
// PORTS
//  clk        in   1                     rising-edge clock, shared with FIFO
//  reset      in   1                     synchronous, active-low reset
//  empty      in   1                     FIFO empty flag
//  read_req   out  1                     FIFO pop; read_data valid exactly 1 cycle later
//  read_data  in   DATA_W                FIFO registered read data
//  out_valid  out  1                     word available
//  out_ready  in   1                     sink accepts word when out_valid&&out_ready
//  out_data   out  DATA_W*BYTES_PER_WORD packed word; byte0 = first popped byte in [DATA_W-1:0]
//  out_keep   out  BYTES_PER_WORD        per-byte valid mask; all-ones except on timeout flush
// BEHAVIOUR
//  - Reset (reset==0 at posedge): read_req=0, out_valid=0, out_data=0, out_keep=0, counters=0,
//    in-flight flag cleared, state=FILL. A byte in flight at reset is discarded.
//  - States: FILL (popping/collecting), HOLD (out_valid=1, waiting out_ready).
//  - read_req combinational: state==FILL && !empty && (issued < BYTES_PER_WORD); never asserted
//    in HOLD, never when empty (no underflow pops).
//  - issued = bytes captured + in-flight (0/1); back-to-back pops allowed: 1 byte/cycle sustained.
//  - in_flight <= read_req each cycle; when in_flight==1 capture read_data into lane count,
//    count++ (width clog2(BYTES_PER_WORD)+1).
//  - Capture completing count==BYTES_PER_WORD: next cycle state=HOLD, out_valid=1, keep=all-ones.
//  - HOLD: out_data/out_keep stable while out_valid&&!out_ready. On handshake: count=0,
//    data cleared, state=FILL; first new read_req earliest the cycle after handshake.
//  - Idle counter: runs in FILL when 0<count<BYTES_PER_WORD, no in-flight byte, empty==1;
//    reset to 0 on any pop/capture. Reaching TIMEOUT: HOLD with out_keep=(1<<count)-1,
//    unfilled lanes zero. count==0 never flushes (no empty words).
//  - Simultaneous: capture of final byte and timeout same cycle -> full word, keep all-ones.
//  - empty deasserting during HOLD: no pop until handshake.
//  - Throughput: full word latency from first read_req = BYTES_PER_WORD+1 cycles to out_valid.
// STRUCTURE
//  - Package fifo_pkg: DATA_W default, BYTES_PER_WORD default, state enum {FILL,HOLD}.
//  - Single module; no sub-module needed. Idle timer may be a small sub-module
//    fifo_idle_timer (count, clear, enable, expire) if reused by the FIFO write side.
//  - Bench instantiates fifo_dut + fifo_word_packer back-to-back, same clk/reset.
// TESTING
//  1. Write 0x11,0x22,0x33,0x44, out_ready=1 -> one word out_data=0x44332211, keep=4'hF;
//     read_req high exactly 4 cycles.
//  2. Write 0x01..0x08 with out_ready=0 -> word0 0x04030201 held stable, no read_req while HOLD;
//     raise out_ready -> 0x04030201 then 0x08070605, FIFO empty at end.
//  3. Write 0xAA,0xBB then idle -> after 16 idle cycles word 0x0000BBAA, keep=4'h3.
//  4. Write 256 bytes 0x00..0xFF (FIFO full), out_ready=1 -> 64 words, incrementing bytes,
//     no loss across pointer wrap, read_req never while empty.
//  5. Assert reset (low) one cycle with byte in flight and count=2 -> out_valid=0, keep=0;
//     after reset, next 4 bytes form a clean word with keep=4'hF.
//  6. Toggle out_ready randomly for 1000 bytes -> output stream equals input order, no duplicates.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the byte-FIFO drain path (word packer and idle timer).
package fifo_pkg;

  localparam int DATA_W_DEF         = 8;
  localparam int BYTES_PER_WORD_DEF = 4;
  localparam int TIMEOUT_DEF        = 16;

  // FILL: popping bytes and collecting them into the word register.
  // HOLD: word presented on the output port, waiting for the sink.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Low-order mask with n ones, n in 0..8 (byte-enable for a partial word).
  function automatic logic [7:0] lane_mask(input logic [3:0] n);
    logic [8:0] m;
    m = (9'd1 << n) - 9'd1;
    return m[7:0];
  endfunction

endpackage

// File: rtl/fifo_idle_timer.sv
// Idle cycle counter: counts consecutive enabled cycles and pulses expire on the
// TIMEOUT-th one. Any clear, or a cycle without enable, restarts the count.
module fifo_idle_timer #(
  parameter int TIMEOUT = 16,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CW-1:0] count_q;

  // Count idle cycles, saturating at TIMEOUT so the counter never wraps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear || !enable) begin
      count_q <= '0;
    end else if (count_q != CW'(TIMEOUT)) begin
      count_q <= count_q + CW'(1);
    end
  end

  // Expire during the TIMEOUT-th consecutive idle cycle so the owner acts on that edge.
  always_comb begin
    expire = enable && !clear && (count_q == CW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Drain stage for the byte FIFO: pops bytes, packs them little-endian into a word
// and presents the word on a valid/ready port. A partial word is flushed with a
// byte-enable mask after the FIFO has stayed empty for TIMEOUT idle cycles.
//
// Output handshake: out_valid is raised only in HOLD and stays high, with
// out_data/out_keep unchanged, until the cycle where out_valid && out_ready; that
// edge transfers the word. out_ready may toggle freely and never affects out_valid
// combinationally.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int TIMEOUT        = TIMEOUT_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             empty,
  output logic                             read_req,
  input  logic [DATA_W-1:0]                read_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_W*BYTES_PER_WORD-1:0] out_data,
  output logic [BYTES_PER_WORD-1:0]        out_keep,
  output state_e                           dbg_state
);

  localparam int LW = $clog2(BYTES_PER_WORD);
  localparam int CW = LW + 1;
  localparam logic [CW-1:0] FULL = CW'(BYTES_PER_WORD);

  state_e                           state_q, state_d;
  logic [CW-1:0]                    count_q;
  logic                             in_flight_q;
  logic [DATA_W*BYTES_PER_WORD-1:0] data_q;
  logic [BYTES_PER_WORD-1:0]        keep_q;

  logic [CW-1:0]             issued;
  logic                      capture;
  logic                      capture_last;
  logic                      handshake;
  logic                      idle_en;
  logic                      idle_clr;
  logic                      expire;
  logic [BYTES_PER_WORD-1:0] flush_keep;

  // Derived control: pop gating, capture strobes and idle-timer conditions.
  always_comb begin
    issued       = count_q + {{(CW-1){1'b0}}, in_flight_q};
    capture      = in_flight_q;
    capture_last = in_flight_q && (count_q == FULL - CW'(1));
    handshake    = (state_q == HOLD) && out_ready;
    // Timer only runs on a genuinely stalled partial word; an empty word never flushes.
    idle_en      = (state_q == FILL) && (count_q != '0) && (count_q < FULL)
                   && !in_flight_q && empty;
    idle_clr     = read_req || in_flight_q;
    flush_keep   = BYTES_PER_WORD'(lane_mask(4'(count_q)));
  end

  fifo_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (idle_clr),
    .enable (idle_en),
    .expire (expire)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and combinational outputs; a final capture wins over a timeout.
  always_comb begin
    state_d   = state_q;
    read_req  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      FILL: begin
        // Pops are limited so captured plus in-flight bytes never exceed one word.
        read_req = !empty && (issued < FULL);
        if (capture_last) begin
          state_d = HOLD;
        end else if (expire) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Byte collection: in-flight tracking, lane capture, keep mask and word clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_flight_q <= 1'b0;
      count_q     <= '0;
      data_q      <= '0;
      keep_q      <= '0;
    end else begin
      // FIFO read data is valid exactly one cycle after the pop.
      in_flight_q <= read_req;
      if (handshake) begin
        count_q <= '0;
        data_q  <= '0;
        keep_q  <= '0;
      end else if (capture) begin
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
          if (count_q[LW-1:0] == LW'(i)) begin
            data_q[i*DATA_W +: DATA_W] <= read_data;
          end
        end
        count_q <= count_q + CW'(1);
        if (capture_last) begin
          keep_q <= '1;
        end
      end else if (expire) begin
        // Unfilled lanes are already zero from the previous word clear.
        keep_q <= flush_keep;
      end
    end
  end

  // Registered word, mask and state straight to the ports.
  always_comb begin
    out_data  = data_q;
    out_keep  = keep_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: a behavioural 256x8 FIFO feeds the packer, a byte
// scoreboard predicts each output word, and a monitor checks pop rules and timing.
module tb_fifo_word_packer;
  import fifo_pkg::*;

  localparam int BPW   = 4;
  localparam int TO    = 16;
  localparam int DEPTH = 256;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        empty;
  logic        read_req;
  logic [7:0]  read_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  state_e      dbg_state;

  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  fifo_word_packer #(
    .DATA_W         (8),
    .BYTES_PER_WORD (BPW),
    .TIMEOUT        (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .empty     (empty),
    .read_req  (read_req),
    .read_data (read_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .dbg_state (dbg_state)
  );

  // ---------------- behavioural byte FIFO ----------------
  logic [7:0] fifo_q[$];

  always @(posedge clk) begin
    if (!reset) begin
      fifo_q.delete();
      read_data <= 8'h00;
    end else begin
      if (read_req && fifo_q.size() != 0) read_data <= fifo_q.pop_front();
      if (wr_en && fifo_q.size() < DEPTH) fifo_q.push_back(wr_data);
    end
    empty <= (fifo_q.size() == 0);
  end

  // ---------------- checking ----------------
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [7:0]  exp_q[$];
  int          cyc = 0;
  int          words_out = 0;
  int          rr_total = 0;
  int          rr_in_word = 0;
  int          word_first = 0;
  int          word_last = 0;
  int          last_rr = 0;
  bit          word_started = 0;
  bit          prev_valid = 0;
  bit          prev_ready = 0;
  logic [31:0] hold_data;
  logic [3:0]  hold_keep;
  int          sb_n;
  logic [31:0] sb_data;
  logic [3:0]  sb_keep;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      word_started = 0;
      rr_in_word   = 0;
      prev_valid   = 0;
      prev_ready   = 0;
    end else begin
      if (read_req) begin
        check("rr_while_empty", {31'b0, empty}, 32'd0);
        check("rr_while_hold", {31'b0, out_valid}, 32'd0);
        rr_total++;
        rr_in_word++;
        if (!word_started) begin
          word_started = 1;
          word_first   = cyc;
        end
        word_last = cyc;
        last_rr   = cyc;
      end
      if (out_valid && !prev_valid) begin
        hold_data = out_data;
        hold_keep = out_keep;
        if (out_keep == 4'hF) begin
          if (rr_in_word == BPW && word_last - word_first == BPW - 1)
            check("full_latency", 32'(cyc - word_first), 32'(BPW + 1));
        end else begin
          check("flush_latency", 32'(cyc - last_rr), 32'(TO + 2));
        end
      end else if (out_valid && prev_valid && !prev_ready) begin
        check("hold_data_stable", out_data, hold_data);
        check("hold_keep_stable", {28'b0, out_keep}, {28'b0, hold_keep});
      end
      if (out_valid && out_ready) begin
        // A word carries up to BPW of the oldest outstanding bytes; fewer only on a flush.
        sb_n    = (exp_q.size() >= BPW) ? BPW : exp_q.size();
        sb_keep = 4'((1 << sb_n) - 1);
        sb_data = '0;
        for (int i = 0; i < sb_n; i++) sb_data[i*8 +: 8] = exp_q.pop_front();
        check("word_keep", {28'b0, out_keep}, {28'b0, sb_keep});
        check("word_data", out_data, sb_data);
        words_out++;
        word_started = 0;
        rr_in_word   = 0;
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    check("fifo_room", {31'b0, fifo_q.size() < DEPTH}, 32'd1);
    wr_en   = 1'b1;
    wr_data = b;
    exp_q.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  int rr0;
  int w0;

  initial begin
    // reset state
    reset = 1'b0;
    repeat (3) tick();
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_keep", {28'b0, out_keep}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_read_req", {31'b0, read_req}, 32'd0);
    reset = 1'b1;
    tick();

    // one full word
    out_ready = 1'b1;
    rr0 = rr_total;
    w0  = words_out;
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33); write_byte(8'h44);
    wait_drain(100);
    check("t1_rr_cycles", 32'(rr_total - rr0), 32'd4);
    check("t1_words", 32'(words_out - w0), 32'd1);

    // back-pressure: first word held, no pops while holding
    out_ready = 1'b0;
    rr0 = rr_total;
    w0  = words_out;
    for (int i = 1; i <= 8; i++) write_byte(8'(i));
    repeat (20) tick();
    check("t2_valid_held", {31'b0, out_valid}, 32'd1);
    check("t2_word0_data", out_data, 32'h04030201);
    check("t2_rr_while_held", 32'(rr_total - rr0), 32'd4);
    out_ready = 1'b1;
    wait_drain(100);
    check("t2_words", 32'(words_out - w0), 32'd2);
    check("t2_fifo_empty", {31'b0, empty}, 32'd1);

    // partial word flushed by idle timeout
    w0 = words_out;
    write_byte(8'hAA); write_byte(8'hBB);
    for (int i = 0; i < 100; i++) begin
      if (out_valid) break;
      tick();
    end
    check("t3_valid", {31'b0, out_valid}, 32'd1);
    check("t3_keep", {28'b0, out_keep}, 32'h3);
    check("t3_data", out_data, 32'h0000BBAA);
    wait_drain(100);
    check("t3_words", 32'(words_out - w0), 32'd1);

    // 256 bytes through the FIFO, pointer wrap
    out_ready = 1'b0;
    w0 = words_out;
    for (int i = 0; i < 256; i++) write_byte(8'(i));
    out_ready = 1'b1;
    wait_drain(2000);
    check("t4_words", 32'(words_out - w0), 32'd64);

    // reset with a byte in flight and two bytes captured
    write_byte(8'h51); write_byte(8'h52); write_byte(8'h53); write_byte(8'h54);
    for (int i = 0; i < 50; i++) begin
      if (rr_in_word >= 3) break;
      tick();
    end
    check("t5_third_pop_seen", {31'b0, rr_in_word >= 3}, 32'd1);
    reset = 1'b0;
    exp_q.delete();
    tick();
    check("t5_rst_valid", {31'b0, out_valid}, 32'd0);
    check("t5_rst_keep", {28'b0, out_keep}, 32'd0);
    check("t5_rst_data", out_data, 32'd0);
    reset = 1'b1;
    tick();
    w0 = words_out;
    write_byte(8'h61); write_byte(8'h62); write_byte(8'h63); write_byte(8'h64);
    wait_drain(100);
    check("t5_words", 32'(words_out - w0), 32'd1);

    // random back-pressure and write gaps
    w0 = words_out;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
      out_ready = 1'($urandom_range(0, 1));
      write_byte(8'($urandom_range(0, 255)));
    end
    out_ready = 1'b1;
    wait_drain(1000);
    check("t6_words", 32'(words_out - w0), 32'd250);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
